pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 154 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: start synchronizer, serve/play/point/over flow, scoring and LCD refresh pulse.
// All outputs registered; start edge is only honoured once iniciar has been seen low after reset.
module pong_game_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int WIN_SCORE    = 7
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       iniciar,
  input  logic       frame_tick,
  input  logic       miss_l,
  input  logic       miss_r,
  input  logic [7:0] rand_num,
  output logic       ball_en,
  output logic       ball_load,
  output logic [1:0] serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] state,
  output logic       lcd_update
);

  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       score_l_d, score_r_d;
  logic [1:0]       winner_d;
  logic             load_d;
  logic             chg_q;

  logic [1:0] sync_q;
  logic [1:0] fill_q;
  logic       armed_q;
  logic       start;
  logic       unused_rand;

  assign unused_rand = ^rand_num[7:2];

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // armed_q only rises after the pipeline holds real samples and shows a low,
  // so iniciar held high through reset release never looks like an edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q  <= 2'b00;
      fill_q  <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], iniciar};
      fill_q  <= (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
      armed_q <= (fill_q == 2'd2) && !sync_q[1];
    end
  end

  assign start = armed_q && sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_l_d = score_l;
    score_r_d = score_r;
    winner_d  = winner;
    load_d    = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d   = SERVE;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          winner_d  = 2'b00;
          load_d    = 1'b1;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) state_d = PLAY;
          else                     cnt_d   = cnt_q + 1'b1;
        end
      end
      PLAY: begin
        if (miss_l && !miss_r) score_r_d = sat_inc(score_r);
        if (miss_r && !miss_l) score_l_d = sat_inc(score_l);
        if (miss_l || miss_r)  state_d   = POINT;
      end
      POINT: begin
        if (frame_tick) begin
          if (cnt_q == POINT_LAST) begin
            if (score_l == WIN) begin
              state_d  = OVER;
              winner_d = 2'b01;
            end else if (score_r == WIN) begin
              state_d  = OVER;
              winner_d = 2'b10;
            end else begin
              state_d = SERVE;
              load_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      winner     <= 2'b00;
      ball_en    <= 1'b0;
      ball_load  <= 1'b0;
      serve_dir  <= 2'b00;
      chg_q      <= 1'b0;
      lcd_update <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score_l   <= score_l_d;
      score_r   <= score_r_d;
      winner    <= winner_d;
      ball_en   <= (state_d == PLAY);
      ball_load <= load_d;
      if (load_d) serve_dir <= rand_num[1:0];
      // lcd_update trails the visible register change by one cycle
      chg_q      <= (score_l_d != score_l) || (score_r_d != score_r) || (winner_d != winner);
      lcd_update <= chg_q;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized and directed bench for pong_game_ctrl against a behavioural match model.
module tb_pong_game_ctrl;

  localparam int SF = 4;
  localparam int PF = 3;
  localparam int WS = 2;
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b1;
  logic       iniciar = 1'b0;
  logic       frame_tick = 1'b0;
  logic       miss_l = 1'b0;
  logic       miss_r = 1'b0;
  logic [7:0] rand_num = 8'd0;
  logic       ball_en, ball_load, lcd_update;
  logic [1:0] serve_dir, winner;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  int n_chk = 0;
  int n_fail = 0;

  pong_game_ctrl #(.SERVE_FRAMES(SF), .POINT_FRAMES(PF), .WIN_SCORE(WS)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .iniciar(iniciar), .frame_tick(frame_tick),
    .miss_l(miss_l), .miss_r(miss_r), .rand_num(rand_num),
    .ball_en(ball_en), .ball_load(ball_load), .serve_dir(serve_dir),
    .score_l(score_l), .score_r(score_r), .winner(winner), .state(state),
    .lcd_update(lcd_update)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: match phase, frames seen in the phase, scores, winner.
  int m_st, m_frames, m_sl, m_sr, m_win, m_dir, m_load, m_chg, m_lcd, edge_n;
  bit h1, h2, h3;

  always @(posedge Clock) begin
    int psl, psr, pwin;
    bit go;
    if (!Reset_n) begin
      m_st = S_IDLE; m_frames = 0; m_sl = 0; m_sr = 0; m_win = 0;
      m_dir = 0; m_load = 0; m_chg = 0; m_lcd = 0; edge_n = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      edge_n++;
      // start = 0->1 between consecutive post-reset samples, acted on two edges later
      go = (edge_n >= 4) && !h3 && h2;
      h3 = h2; h2 = h1; h1 = iniciar;
      psl = m_sl; psr = m_sr; pwin = m_win;
      m_lcd = m_chg;
      m_load = 0;
      case (m_st)
        S_IDLE, S_OVER: if (go) begin
          m_st = S_SERVE; m_sl = 0; m_sr = 0; m_win = 0; m_load = 1; m_frames = 0;
        end
        S_SERVE: if (frame_tick) begin
          m_frames++;
          if (m_frames == SF) begin m_st = S_PLAY; m_frames = 0; end
        end
        S_PLAY: begin
          if (miss_l && !miss_r) m_sr = (m_sr < 15) ? m_sr + 1 : 15;
          if (miss_r && !miss_l) m_sl = (m_sl < 15) ? m_sl + 1 : 15;
          if (miss_l || miss_r) begin m_st = S_POINT; m_frames = 0; end
        end
        S_POINT: if (frame_tick) begin
          m_frames++;
          if (m_frames == PF) begin
            m_frames = 0;
            if (m_sl == WS)      begin m_st = S_OVER; m_win = 1; end
            else if (m_sr == WS) begin m_st = S_OVER; m_win = 2; end
            else                 begin m_st = S_SERVE; m_load = 1; end
          end
        end
        default: m_st = S_IDLE;
      endcase
      if (m_load != 0) m_dir = int'(rand_num[1:0]);
      m_chg = (psl != m_sl || psr != m_sr || pwin != m_win) ? 1 : 0;
    end
    #1;
    chk("state", int'(state), m_st);
    chk("ball_en", int'(ball_en), (m_st == S_PLAY) ? 1 : 0);
    chk("ball_load", int'(ball_load), m_load);
    chk("serve_dir", int'(serve_dir), m_dir);
    chk("score_l", int'(score_l), m_sl);
    chk("score_r", int'(score_r), m_sr);
    chk("winner", int'(winner), m_win);
    chk("lcd_update", int'(lcd_update), m_lcd);
  end

  always @(negedge Clock) rand_num = 8'($urandom);

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge Clock);
    frame_tick = 1'b0;
    @(negedge Clock);
  endtask

  task automatic pulse_miss(input bit l, input bit r);
    miss_l = l;
    miss_r = r;
    @(negedge Clock);
    miss_l = 1'b0;
    miss_r = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse_tick();
  endtask

  initial begin
    int tog;
    #1 Reset_n = 1'b0;
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_outputs", int'({ball_en, ball_load, serve_dir, score_l, score_r, winner, lcd_update}), 0);
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    repeat (5) @(negedge Clock);

    // start: sampled at next edge, acted on two edges later
    iniciar = 1'b1;
    repeat (2) @(negedge Clock);
    chk("no_early_start", int'(state), S_IDLE);
    @(negedge Clock);
    chk("start_serve", int'(state), S_SERVE);
    chk("start_load", int'(ball_load), 1);
    @(negedge Clock);
    chk("load_one_cycle", int'(ball_load), 0);

    ticks(3);
    chk("serve_wait", int'(state), S_SERVE);
    pulse_tick();
    chk("play", int'(state), S_PLAY);
    chk("play_en", int'(ball_en), 1);

    pulse_miss(1'b0, 1'b1);
    chk("miss_r_score_l", int'(score_l), 1);
    chk("miss_r_point", int'(state), S_POINT);
    chk("lcd_not_yet", int'(lcd_update), 0);
    @(negedge Clock);
    chk("lcd_pulse", int'(lcd_update), 1);
    ticks(PF);
    chk("point_to_serve", int'(state), S_SERVE);

    ticks(SF);
    pulse_miss(1'b1, 1'b1);
    chk("both_point", int'(state), S_POINT);
    @(negedge Clock);
    chk("both_no_lcd", int'(lcd_update), 0);
    chk("both_scores", int'({score_l, score_r}), 8'h10);
    ticks(PF);

    ticks(SF);
    pulse_miss(1'b1, 1'b0);
    ticks(PF);
    ticks(SF);
    pulse_miss(1'b1, 1'b0);
    chk("score_r_two", int'(score_r), 2);
    ticks(PF);
    chk("over", int'(state), S_OVER);
    chk("winner_right", int'(winner), 2);

    for (int i = 0; i < 12; i++) begin
      frame_tick = 1'($urandom);
      miss_l = 1'($urandom);
      miss_r = 1'($urandom);
      @(negedge Clock);
    end
    frame_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    chk("over_hold", int'(state), S_OVER);
    chk("over_scores", int'({score_l, score_r}), 8'h12);

    iniciar = 1'b0;
    repeat (3) @(negedge Clock);
    iniciar = 1'b1;
    repeat (3) @(negedge Clock);
    chk("restart_serve", int'(state), S_SERVE);
    chk("restart_clear", int'({score_l, score_r, winner}), 0);

    for (int i = 0; i < 3000; i++) begin
      frame_tick = 1'($urandom);
      miss_l = ($urandom_range(5) == 0);
      miss_r = ($urandom_range(5) == 0);
      if ($urandom_range(19) == 0) iniciar = ~iniciar;
      @(negedge Clock);
    end
    frame_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;

    tog = 0;
    for (int i = 0; i < 500; i++) begin
      frame_tick = 1'b0; miss_l = 1'b0;
      if (state == 3'(S_POINT)) break;
      if (state == 3'(S_SERVE)) frame_tick = 1'b1;
      if (state == 3'(S_PLAY)) miss_l = 1'b1;
      if (state == 3'(S_IDLE) || state == 3'(S_OVER)) begin
        tog++;
        if (tog % 4 == 0) iniciar = ~iniciar;
      end
      @(negedge Clock);
    end
    chk("reach_point", int'(state), S_POINT);
    pulse_tick();
    iniciar = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_outputs", int'({ball_en, ball_load, serve_dir, score_l, score_r, winner, lcd_update}), 0);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    repeat (20) @(negedge Clock);
    chk("held_iniciar_idle", int'(state), S_IDLE);
    chk("held_iniciar_noload", int'(ball_load), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
